apb_upsizer_gen: RTL
====================

Name: apb_upsizer_gen

Overview:
Parametrised APB width converter bridging a narrow APB master (M_DW) to a wide APB slave (S_DW), the successor of the fixed 16->32 upsizer. It adds generic power-of-two width ratios, byte-lane steering, PSLVERR propagation, a slave-timeout watchdog and an optional one-entry read buffer that serves narrow reads of the same wide word without a slave access. It sits between the narrow control bus and the 32/64-bit crypto accelerator register banks.

Parameters:
M_DW, 16, master data width; 8, 16 or 32.
S_DW, 32, slave data width; power-of-two multiple of M_DW, max 128.
AW, 32, address width.
RD_BUF, 1, 1 enables the one-entry wide read buffer; 0 sends every read to the slave.
TIMEOUT, 0, ACCESS-phase cycles before abort; 0 disables.

Ports:
pclk  in  1  clock
prst  in  1  synchronous active-high reset
psel_m_i  in  1  master select
penable_m_i  in  1  master enable
pwrite_m_i  in  1  master write
paddr_m_i  in  AW  master byte address
pwdata_m_i  in  M_DW  master write data
pstrb_m_i  in  M_DW/8  master byte strobes
prdata_m_o  out  M_DW  read data to master
pready_m_o  out  1  ready to master
pslverr_m_o  out  1  error to master
psel_s_o  out  1  slave select
penable_s_o  out  1  slave enable
pwrite_s_o  out  1  slave write
paddr_s_o  out  AW  slave address, aligned to S_DW/8 bytes
pwdata_s_o  out  S_DW  slave write data
pstrb_s_o  out  S_DW/8  slave strobes
prdata_s_i  in  S_DW  slave read data
pready_s_i  in  1  slave ready
pslverr_s_i  in  1  slave error
flush_i  in  1  invalidate read buffer

Behaviour:
- Reset (prst=1 at a pclk edge): FSM to IDLE; every output 0; buffer valid=0, timeout counter 0. Reset mid-transfer abandons the transfer immediately, with no response to the master.
- Lane index L = paddr_m_i[log2(S_DW/8)-1 : log2(M_DW/8)]; tag = paddr_m_i[AW-1 : log2(S_DW/8)].
- All slave-side outputs and master responses are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: on psel_m_i=1 and penable_m_i=0, latch addr, write, data, strobes and L.
  - Read hit (RD_BUF=1, valid, tag match, flush_i=0) -> RESP.
  - Otherwise -> SETUP.
- SETUP: psel_s_o=1, penable_s_o=0, paddr_s_o={tag, zeros}, pwrite_s_o=latched write.
  - pwdata_s_o = master data replicated R=S_DW/M_DW times.
  - pstrb_s_o = pstrb_m_i placed at lane L; all other strobe bits 0; all strobe bits 0 for reads.
  - Next state ACCESS.
- ACCESS: penable_s_o=1.
  - pready_s_i=1 -> capture lane L of prdata_s_i and pslverr_s_i; drop psel_s_o and penable_s_o; -> RESP.
  - TIMEOUT>0 and counter reaches TIMEOUT without pready_s_i -> drop slave signals, prdata=0, pslverr=1, -> RESP.
  - Counter clears on entry to ACCESS.
- RESP: pready_m_o=1 for exactly one cycle, with prdata_m_o and pslverr_m_o valid (prdata_m_o=0 for writes); -> IDLE. prdata_m_o and pslverr_m_o return to 0 next cycle.
- Latency from master setup cycle (cycle 0) to pready_m_o:
  - Miss: psel_s_o at cycle 1, penable_s_o at cycle 2, pready_m_o at cycle 3 plus slave wait states.
  - Hit: pready_m_o at cycle 1.
- Buffer:
  - Successful read miss (pslverr_s_i=0) stores the full S_DW word and tag, and sets valid.
  - An errored or timed-out read to the buffered tag clears valid.
  - Any write whose tag matches clears valid, whether or not it errors.
  - flush_i=1 clears valid. In the cycle of a fill, flush wins.
  - flush_i=1 in IDLE with a hitting read forces a miss.
- Master dropping psel_m_i mid-transfer is a protocol violation: the block completes the slave transfer and still pulses pready_m_o.
- Back-to-back: a new master setup is accepted in the first IDLE cycle after RESP.

Test Plan:
- Write 16->32 at 0x2, data 0x6677, strb 2'b11 -> slave addr 0x0, pwdata 0x66776677, pstrb 4'b1100, pready_m_o at cycle 3 with pready_s_i=1.
- Read 0x4 with slave 0x99998888, then read 0x6 -> first returns 0x8888 (miss, one slave access); second returns 0x9999 at cycle 1 with no psel_s_o.
- Write 0x4 between those reads -> buffer invalidated; the following read of 0x6 accesses the slave again.
- TIMEOUT=4, pready_s_i held 0 -> abort after 4 ACCESS cycles: pslverr_m_o=1, prdata_m_o=0, psel_s_o/penable_s_o=0.
- pslverr_s_i=1 on a read -> pslverr_m_o=1; next read to same word misses; flush_i pulsed during a fill leaves valid=0.
- M_DW=8, S_DW=64, write 0xA5 to 0x13 -> pstrb_s_o=8'b0000_1000, paddr_s_o=0x10; prst asserted in ACCESS -> all outputs 0 next edge.

Source files
------------

// File: rtl/apb_upsizer_gen.sv
// Narrow-to-wide APB bridge: lane steering, error/timeout propagation and an
// optional one-entry wide read buffer that serves narrow reads of the same word.
module apb_upsizer_gen #(
  parameter int unsigned M_DW    = 16,
  parameter int unsigned S_DW    = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned RD_BUF  = 1,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel_m_i,
  input  logic              penable_m_i,
  input  logic              pwrite_m_i,
  input  logic [AW-1:0]     paddr_m_i,
  input  logic [M_DW-1:0]   pwdata_m_i,
  input  logic [M_DW/8-1:0] pstrb_m_i,
  output logic [M_DW-1:0]   prdata_m_o,
  output logic              pready_m_o,
  output logic              pslverr_m_o,
  output logic              psel_s_o,
  output logic              penable_s_o,
  output logic              pwrite_s_o,
  output logic [AW-1:0]     paddr_s_o,
  output logic [S_DW-1:0]   pwdata_s_o,
  output logic [S_DW/8-1:0] pstrb_s_o,
  input  logic [S_DW-1:0]   prdata_s_i,
  input  logic              pready_s_i,
  input  logic              pslverr_s_i,
  input  logic              flush_i
);

  localparam int unsigned MB = M_DW / 8;
  localparam int unsigned SB = S_DW / 8;
  localparam int unsigned R  = S_DW / M_DW;
  localparam int unsigned LO = $clog2(MB);
  localparam int unsigned HI = $clog2(SB);
  localparam int unsigned LW = (HI > LO) ? HI - LO : 1;
  localparam int unsigned TW = AW - HI;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tag_q;
  logic [LW-1:0]     lane_q;
  logic              write_q;
  logic [CW-1:0]     cnt_q;

  logic              buf_valid_q;
  logic [TW-1:0]     buf_tag_q;
  logic [S_DW-1:0]   buf_data_q;

  logic              psel_d, penable_d, pwrite_d, pready_d, pslverr_d;
  logic [AW-1:0]     paddr_d;
  logic [S_DW-1:0]   pwdata_d;
  logic [SB-1:0]     pstrb_d;
  logic [M_DW-1:0]   prdata_d;

  logic [TW-1:0]     tag_c;
  logic [LW-1:0]     lane_c;
  logic              setup_c, hit_c, timeout_c, done_c, err_c;
  logic [SB-1:0]     wide_strb_c;
  logic [M_DW-1:0]   buf_lane_c, rsp_lane_c;

  // Address decode and lane selection for the incoming / latched transfer
  always_comb begin
    tag_c       = paddr_m_i[AW-1:HI];
    lane_c      = LW'(paddr_m_i >> LO) & LW'(R - 1);
    setup_c     = psel_m_i & ~penable_m_i;
    hit_c       = (RD_BUF != 0) && buf_valid_q && !pwrite_m_i &&
                  (buf_tag_q == tag_c) && !flush_i;
    timeout_c   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    done_c      = (state_q == ACCESS) && (pready_s_i || timeout_c);
    err_c       = pready_s_i ? pslverr_s_i : 1'b1;
    wide_strb_c = SB'(pstrb_m_i) << (32'(lane_c) * MB);
    buf_lane_c  = M_DW'(buf_data_q >> (32'(lane_c) * M_DW));
    rsp_lane_c  = M_DW'(prdata_s_i >> (32'(lane_q) * M_DW));
  end

  // Next state and next registered outputs; slave bus fields hold by default
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_s_o;
    penable_d = penable_s_o;
    pwrite_d  = pwrite_s_o;
    paddr_d   = paddr_s_o;
    pwdata_d  = pwdata_s_o;
    pstrb_d   = pstrb_s_o;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup_c) begin
          if (hit_c) begin
            state_d  = RESP;
            pready_d = 1'b1;
            prdata_d = buf_lane_c;
          end else begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = pwrite_m_i;
            paddr_d   = paddr_m_i & ~AW'(SB - 1);
            pwdata_d  = {R{pwdata_m_i}};
            pstrb_d   = pwrite_m_i ? wide_strb_c : '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready_s_i) begin
          state_d   = RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pready_d  = 1'b1;
          prdata_d  = write_q ? '0 : rsp_lane_c;
          pslverr_d = pslverr_s_i;
        end else if (timeout_c) begin
          state_d   = RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, transfer context, watchdog and registered outputs
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      lane_q      <= '0;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      psel_s_o    <= 1'b0;
      penable_s_o <= 1'b0;
      pwrite_s_o  <= 1'b0;
      paddr_s_o   <= '0;
      pwdata_s_o  <= '0;
      pstrb_s_o   <= '0;
      pready_m_o  <= 1'b0;
      prdata_m_o  <= '0;
      pslverr_m_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (state_q == IDLE && setup_c) begin
        tag_q   <= tag_c;
        lane_q  <= lane_c;
        write_q <= pwrite_m_i;
      end
      cnt_q       <= (state_q == ACCESS) ? cnt_q + CW'(1) : '0;
      psel_s_o    <= psel_d;
      penable_s_o <= penable_d;
      pwrite_s_o  <= pwrite_d;
      paddr_s_o   <= paddr_d;
      pwdata_s_o  <= pwdata_d;
      pstrb_s_o   <= pstrb_d;
      pready_m_o  <= pready_d;
      prdata_m_o  <= prdata_d;
      pslverr_m_o <= pslverr_d;
    end
  end

  // Read buffer: fill on clean read miss, drop on error or write to the same word; flush wins
  always_ff @(posedge pclk) begin
    if (prst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      if (done_c && (RD_BUF != 0)) begin
        if (!write_q && !err_c) begin
          buf_valid_q <= 1'b1;
          buf_tag_q   <= tag_q;
          buf_data_q  <= prdata_s_i;
        end else if (buf_tag_q == tag_q) begin
          buf_valid_q <= 1'b0;
        end
      end
      if (flush_i) buf_valid_q <= 1'b0;
    end
  end

endmodule
